// File: rtl/mem_copy_if.sv
// mem_copy_if: CPU programming signals plus RAM port-B bus for the copy engine.
interface mem_copy_if #(parameter int WIDTH = 16);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] src_addr;
    logic [WIDTH-1:0] dst_addr;
    logic [WIDTH-1:0] len;
    logic [WIDTH-1:0] fill_val;
    logic [WIDTH-1:0] q_b;
    logic             we_b;
    logic [WIDTH-1:0] addr_b;
    logic [WIDTH-1:0] data_b;
    logic             busy;
    logic             done;

    modport master (
        output start, mode, src_addr, dst_addr, len, fill_val, q_b,
        input  we_b, addr_b, data_b, busy, done
    );

    modport slave (
        input  start, mode, src_addr, dst_addr, len, fill_val, q_b,
        output we_b, addr_b, data_b, busy, done
    );
endinterface

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: block copy / block fill initiator on RAM port B.
module mem_copy_engine #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    mem_copy_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, RD, WR, FILL, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] src_q, src_d;
    logic [WIDTH-1:0] dst_q, dst_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] fval_q, fval_d;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        fval_d  = fval_q;
        case (state_q)
            IDLE: if (bus.start) begin
                src_d   = bus.src_addr;
                dst_d   = bus.dst_addr;
                cnt_d   = bus.len;
                fval_d  = bus.fill_val;
                state_d = (bus.len == '0) ? DONE : (bus.mode ? FILL : RD);
            end
            RD:   state_d = WR;
            WR: begin
                src_d   = src_q + WIDTH'(1);
                dst_d   = dst_q + WIDTH'(1);
                cnt_d   = cnt_q - WIDTH'(1);
                state_d = (cnt_q == WIDTH'(1)) ? DONE : RD;
            end
            FILL: begin
                dst_d   = dst_q + WIDTH'(1);
                cnt_d   = cnt_q - WIDTH'(1);
                state_d = (cnt_q == WIDTH'(1)) ? DONE : FILL;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            fval_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            fval_q  <= fval_d;
        end
    end

    // In WR the word fetched during RD arrives on q_b and is forwarded straight out.
    assign bus.we_b   = (state_q == WR) || (state_q == FILL);
    assign bus.addr_b = (state_q == RD) ? src_q : bus.we_b ? dst_q : '0;
    assign bus.data_b = (state_q == WR) ? bus.q_b : (state_q == FILL) ? fval_q : '0;
    assign bus.busy   = (state_q == RD) || bus.we_b;
    assign bus.done   = (state_q == DONE);
endmodule
